// File: rtl/bcd_pkg.sv
// Constants and state encoding shared by the BCD<->binary converters.
package bcd_pkg;

    localparam int DIGIT_W       = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int DD_ADJ_THRESH = 8;
    localparam int DD_ADD_THRESH = 5;
    localparam int DD_ADJ        = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CHK,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic         start;
    logic [W-1:0] bcd;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] bin;

    modport master (
        output start,
        output bcd,
        input  busy,
        input  done,
        input  err,
        input  bin
    );

    modport slave (
        input  start,
        input  bcd,
        output busy,
        output done,
        output err,
        output bin
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Per-nibble reverse double-dabble correction and digit validity check.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] corrected,
    output logic               invalid
);

    assign corrected = (d >= DIGIT_W'(DD_ADJ_THRESH))
                     ? d - DIGIT_W'(DD_ADJ) : d;
    assign invalid   = d > DIGIT_W'(BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one shift/correct step per clock.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_to_binary_seq_if.slave  io
);

    localparam int W    = DIGIT_W * DIGITS;
    localparam int ITER = W;
    localparam int CW   = $clog2(ITER + 1);

    state_e          state_q, state_d;
    logic [2*W-1:0]  sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            errp_q, errp_d;
    logic [W-1:0]    bin_q, bin_d;

    logic [2*W-1:0]  shifted;
    logic [W-1:0]    adj_in;
    logic [W-1:0]    adj_out;
    logic [DIGITS-1:0] inv;

    assign shifted = sr_q >> 1;
    // Shared digit cells: validity check in LOAD_CHK, correction in SHIFT.
    assign adj_in  = (state_q == SHIFT) ? shifted[2*W-1:W]
                                        : sr_q[2*W-1:W];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d         (adj_in[i*DIGIT_W +: DIGIT_W]),
            .corrected (adj_out[i*DIGIT_W +: DIGIT_W]),
            .invalid   (inv[i])
        );
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        errp_d  = errp_q;
        bin_d   = bin_q;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    sr_d    = {io.bcd, {W{1'b0}}};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    errp_d  = 1'b0;
                    bin_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD_CHK;
                end
            end
            LOAD_CHK: begin
                state_d = SHIFT;
                // Bad digit: flush the operand and take one final step.
                if (|inv) begin
                    errp_d = 1'b1;
                    sr_d   = '0;
                    cnt_d  = CW'(ITER - 1);
                end
            end
            SHIFT: begin
                sr_d  = {adj_out, shifted[W-1:0]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = errp_q;
                    bin_d   = errp_q ? '0 : shifted[W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
            bin_q   <= bin_d;
        end
    end

    // All BCD weight must have migrated into the binary half by now.
    always @(posedge clk) begin
        if (rst_n && state_q == DONE)
            assert (sr_q[2*W-1:W] == '0);
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.err  = err_q;
    assign io.bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized bench for bcd_to_binary_seq against a decimal reference model.
module tb_bcd_to_binary_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.DIGITS(4)) io4 ();
    bcd_to_binary_seq_if #(.DIGITS(1)) io1 ();

    bcd_to_binary_seq #(.DIGITS(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io4)
    );

    bcd_to_binary_seq #(.DIGITS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void bcd2bin(input logic [15:0] b, input int nd,
                                    output bit bad, output int val);
        val = 0;
        bad = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            int d;
            d = int'(b[i*4 +: 4]);
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        if (bad) val = 0;
    endfunction

    task automatic run4(input logic [15:0] b, input bit noise);
        bit bad;
        int val;
        int lat;
        int bc;
        bcd2bin(b, 4, bad, val);
        @(negedge clk);
        io4.bcd   = b;
        io4.start = 1'b1;
        @(posedge clk);
        #1;
        io4.start = 1'b0;
        chk("acc_bin_clr", io4.bin, 0);
        chk("acc_err_clr", io4.err, 0);
        bc  = int'(io4.busy);
        lat = 0;
        while (!io4.done && lat < 40) begin
            if (noise) begin
                io4.start = 1'($urandom);
                io4.bcd   = 16'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (io4.busy) bc++;
        end
        io4.start = 1'b0;
        chk("done", io4.done, 1);
        chk("latency", lat, bad ? 2 : 17);
        chk("busy_cycles", bc, bad ? 2 : 17);
        chk("bin", io4.bin, val);
        chk("err", io4.err, bad);
        @(posedge clk);
        #1;
        chk("done_pulse", io4.done, 0);
        chk("bin_hold", io4.bin, val);
        chk("err_hold", io4.err, bad);
        if (noise) begin
            bit extra = 1'b0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (io4.busy || io4.done) extra = 1'b1;
            end
            chk("no_extra_accept", extra, 0);
        end
    endtask

    task automatic run1(input logic [3:0] b);
        bit bad;
        int val;
        int lat;
        bcd2bin({12'h0, b}, 1, bad, val);
        @(negedge clk);
        io1.bcd   = b;
        io1.start = 1'b1;
        @(posedge clk);
        #1;
        io1.start = 1'b0;
        lat = 0;
        while (!io1.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("d1_done", io1.done, 1);
        chk("d1_latency", lat, bad ? 2 : 5);
        chk("d1_bin", io1.bin, val);
        chk("d1_err", io1.err, bad);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_abort();
        bit seen = 1'b0;
        @(negedge clk);
        io4.bcd   = 16'h4321;
        io4.start = 1'b1;
        @(posedge clk);
        #1;
        io4.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_busy", io4.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", io4.busy, 0);
        chk("rst_done", io4.done, 0);
        chk("rst_err", io4.err, 0);
        chk("rst_bin", io4.bin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (io4.done || io4.busy) seen = 1'b1;
        end
        chk("rst_no_done", seen, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        io4.start = 1'b0;
        io4.bcd   = '0;
        io1.start = 1'b0;
        io1.bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", io4.busy, 0);
        chk("reset_done", io4.done, 0);
        chk("reset_err", io4.err, 0);
        chk("reset_bin", io4.bin, 0);
        chk("reset_d1", {io1.busy, io1.done, io1.err, io1.bin}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run4(16'h1234, 1'b0);
        run4(16'h9999, 1'b0);
        run4(16'h0000, 1'b0);
        run4(16'h12A4, 1'b0);
        run4(16'h0042, 1'b0);
        run4(16'h0500, 1'b1);
        reset_abort();
        run4(16'h4321, 1'b0);

        run1(4'h7);
        run1(4'hF);
        run1(4'h9);

        for (int n = 0; n < 16; n++) begin
            logic [15:0] b;
            if (n % 2 == 0) begin
                for (int i = 0; i < 4; i++)
                    b[i*4 +: 4] = 4'($urandom_range(9));
            end else begin
                b = 16'($urandom);
            end
            run4(b, 1'b0);
        end
        for (int n = 0; n < 6; n++)
            run1(4'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
